// File: rtl/ahb_addr_decoder13.sv
// rtl/ahb_addr_decoder13.sv - AHB-Lite address decoder, data-phase select and default slave
//
// Purpose:
//   Decodes the top RW bits of HADDR into a one-hot address-phase select for
//   NSLV slaves, registers the data-phase select for the response/read-data
//   muxes, and implements the default slave that answers unmapped active
//   transfers with a two-cycle ERROR response.
//
// Optional feature macro: AHB_DEC_ERRCNT_EN (adds err_cnt / err_cnt_clr).
//
// Ports:
//   hclk          in   system clock, rising edge
//   hreset        in   synchronous reset, active-high
//   haddr         in   [AW-1:0] master address (address phase)
//   htrans        in   [1:0] transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   hready        in   global HREADY (muxed HREADYOUT)
//   hsel          out  [NSLV-1:0] combinational address-phase select
//   dsel          out  [NSLV-1:0] registered data-phase select
//   dsel_def      out  registered data-phase select of the default slave
//   def_hreadyout out  default slave HREADYOUT
//   def_hresp     out  default slave HRESP (1 = ERROR)
//   err_cnt_clr   in   (AHB_DEC_ERRCNT_EN) synchronous error counter clear
//   err_cnt       out  (AHB_DEC_ERRCNT_EN) [7:0] saturating error count

module ahb_addr_decoder13 #(
  parameter int AW   = 32,
  parameter int RW   = 4,
  parameter int NSLV = 13
) (
  input  logic            hclk,
  input  logic            hreset,
  input  logic [AW-1:0]   haddr,
  input  logic [1:0]      htrans,
  input  logic            hready,
  output logic [NSLV-1:0] hsel,
  output logic [NSLV-1:0] dsel,
  output logic            dsel_def,
  output logic            def_hreadyout,
  output logic            def_hresp
`ifdef AHB_DEC_ERRCNT_EN
  ,
  input  logic            err_cnt_clr,
  output logic [7:0]      err_cnt
`endif
);

  typedef enum logic [1:0] {
    DEF_IDLE = 2'd0,
    DEF_ERR1 = 2'd1,
    DEF_ERR2 = 2'd2
  } def_state_e;

  logic [RW-1:0]   region;
  logic            sel_def;
  logic [NSLV-1:0] dsel_d, dsel_q;
  logic            dsel_def_d, dsel_def_q;
  def_state_e      state_d, state_q;

  // Address bits below the region index and htrans[0] do not affect decode.
  logic unused_inputs;
  assign unused_inputs = ^{haddr[AW-RW-1:0], htrans[0]};

  // Region decode. The compare is widened by one bit so that NSLV == 2**RW
  // (no unmapped regions) does not wrap to zero.
  always_comb begin
    region  = haddr[AW-1:AW-RW];
    hsel    = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (region == RW'(i)) hsel[i] = 1'b1;
    end
    sel_def = ({1'b0, region} >= (RW+1)'(NSLV));
  end

  // Data-phase select: captured only when the address phase is accepted.
  always_comb begin
    dsel_d     = dsel_q;
    dsel_def_d = dsel_def_q;
    if (hready) begin
      dsel_d     = hsel;
      dsel_def_d = sel_def;
    end
  end

  // Default slave next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DEF_IDLE: begin
        if (hready && sel_def && htrans[1]) state_d = DEF_ERR1;
      end
      DEF_ERR1: begin
        state_d = DEF_ERR2;
      end
      DEF_ERR2: begin
        // HREADYOUT is high here, so the current address phase completes;
        // a new unmapped active transfer restarts the error pair at once.
        if (sel_def && htrans[1]) state_d = DEF_ERR1;
        else                      state_d = DEF_IDLE;
      end
      default: begin
        state_d = DEF_IDLE;
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      dsel_q     <= '0;
      dsel_def_q <= 1'b0;
      state_q    <= DEF_IDLE;
    end else begin
      dsel_q     <= dsel_d;
      dsel_def_q <= dsel_def_d;
      state_q    <= state_d;
    end
  end

  assign dsel          = dsel_q;
  assign dsel_def      = dsel_def_q;
  assign def_hreadyout = (state_q != DEF_ERR1);
  assign def_hresp     = (state_q != DEF_IDLE);

`ifdef AHB_DEC_ERRCNT_EN
  logic [7:0] err_cnt_d, err_cnt_q;
  logic       err_inc;

  // DEF_ERR1 is only ever entered from DEF_IDLE or DEF_ERR2.
  assign err_inc = (state_d == DEF_ERR1) && (state_q != DEF_ERR1);

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_cnt_clr) begin
      err_cnt_d = 8'd0;
    end else if (err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_ahb_addr_decoder13.sv
// tb/tb_ahb_addr_decoder13.sv - scoreboard testbench for ahb_addr_decoder13

module tb_ahb_addr_decoder13;

  localparam int NS = 13;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hready;
  logic [12:0] hsel, dsel;
  logic        dsel_def, def_hreadyout, def_hresp;
  logic        err_cnt_clr;
  logic [7:0]  err_cnt;

  ahb_addr_decoder13 dut (
    .hclk          (hclk),
    .hreset        (hreset),
    .haddr         (haddr),
    .htrans        (htrans),
    .hready        (hready),
    .hsel          (hsel),
    .dsel          (dsel),
    .dsel_def      (dsel_def),
    .def_hreadyout (def_hreadyout),
    .def_hresp     (def_hresp)
`ifdef AHB_DEC_ERRCNT_EN
    ,
    .err_cnt_clr   (err_cnt_clr),
    .err_cnt       (err_cnt)
`endif
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic [12:0] hsel;
    logic [12:0] dsel;
    logic        dsel_def;
    logic        rdy;
    logic        resp;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: which slave owns the data phase, and how many cycles
  // into an error response the default slave currently is (0 = none).
  int m_owner = -1;   // -1 none, 0..12 mapped slave, 13 default slave
  int m_phase = 0;
  int m_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive inputs, push expectation for this cycle, then
  // advance the model across the coming clock edge.
  task automatic cyc(input logic [31:0] a, input logic [1:0] t, input logic rdy_in,
                     input logic rst, input logic clr);
    exp_t        e;
    int          r;
    int          np;
    logic        rdy;
    logic [12:0] one;
    one = 13'd1;
    @(posedge hclk);
    #1;
    // The global HREADY follows the default slave while it owns the bus.
    rdy = rdy_in;
    if (m_phase == 1)      rdy = 1'b0;
    else if (m_phase == 2) rdy = 1'b1;
    haddr = a; htrans = t; hready = rdy; hreset = rst; err_cnt_clr = clr;
    r = int'(a[31:28]);
    e.hsel     = (r < NS) ? (one << r) : 13'd0;
    e.dsel     = (m_owner >= 0 && m_owner < NS) ? (one << m_owner) : 13'd0;
    e.dsel_def = (m_owner == NS);
    e.rdy      = (m_phase != 1);
    e.resp     = (m_phase != 0);
    e.cnt      = 8'(m_cnt);
    sb_q.push_back(e);
    if (rst) begin
      m_owner = -1; m_phase = 0; m_cnt = 0;
    end else begin
      if (m_phase == 1)                       np = 2;
      else if (rdy && r >= NS && t[1] == 1'b1) np = 1;
      else                                    np = 0;
      if (clr)                         m_cnt = 0;
      else if (np == 1 && m_cnt < 255) m_cnt = m_cnt + 1;
      if (rdy) m_owner = (r >= NS) ? NS : r;
      m_phase = np;
    end
  endtask

  // Directed spot check of the current cycle against fixed values.
  task automatic dchk(input string name, input logic rdy, input logic resp, input logic dd);
    @(negedge hclk);
    #1;
    chk({name, "_hreadyout"}, 32'(def_hreadyout), 32'(rdy));
    chk({name, "_hresp"},     32'(def_hresp),     32'(resp));
    chk({name, "_dsel_def"},  32'(dsel_def),      32'(dd));
  endtask

  // Monitor: every cycle the DUT presents a full output set.
  always @(negedge hclk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("hsel",          32'(hsel),          32'(e.hsel));
      chk("dsel",          32'(dsel),          32'(e.dsel));
      chk("dsel_def",      32'(dsel_def),      32'(e.dsel_def));
      chk("def_hreadyout", 32'(def_hreadyout), 32'(e.rdy));
      chk("def_hresp",     32'(def_hresp),     32'(e.resp));
`ifdef AHB_DEC_ERRCNT_EN
      chk("err_cnt",       32'(err_cnt),       32'(e.cnt));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  initial begin
    hreset = 1'b1; haddr = '0; htrans = T_IDLE; hready = 1'b1; err_cnt_clr = 1'b0;
    repeat (2) @(posedge hclk);

    // Reset values and combinational hsel.
    cyc(32'h3000_0000, T_IDLE, 1, 0, 0);
    @(negedge hclk); #1;
    chk("rst_hsel", 32'(hsel), 32'h0008);
    chk("rst_dsel", 32'(dsel), 32'h0);
    chk("rst_def",  {30'd0, def_hreadyout, def_hresp}, 32'b10);

    // Mapped transfer with wait states.
    cyc(32'h5000_0000, T_NSEQ, 1, 0, 0);
    repeat (3) cyc(32'h1000_0000, T_NSEQ, 0, 0, 0);
    @(negedge hclk); #1;
    chk("wait_dsel_hold", 32'(dsel), 32'h0020);
    cyc(32'h1000_0000, T_NSEQ, 1, 0, 0);
    cyc(32'h0000_0000, T_IDLE, 1, 0, 0);
    @(negedge hclk); #1;
    chk("wait_dsel_next", 32'(dsel), 32'h0002);

    // Single unmapped NONSEQ: two-cycle ERROR then OKAY.
    cyc(32'hE000_0000, T_NSEQ, 1, 0, 0);
    cyc(32'hE000_0000, T_IDLE, 1, 0, 0);
    dchk("err1", 0, 1, 1);
    cyc(32'hE000_0000, T_IDLE, 1, 0, 0);
    dchk("err2", 1, 1, 1);
    cyc(32'hE000_0000, T_IDLE, 1, 0, 0);
    dchk("err_done", 1, 0, 1);

    // Back-to-back errors: SEQ presented during DEF_ERR2.
    cyc(32'hF000_0000, T_NSEQ, 1, 0, 0);
    cyc(32'hF000_0000, T_SEQ,  1, 0, 0);
    cyc(32'hF000_0000, T_SEQ,  1, 0, 0);
    cyc(32'hF000_0000, T_IDLE, 1, 0, 0);
    dchk("b2b_err1", 0, 1, 1);
    cyc(32'hF000_0000, T_IDLE, 1, 0, 0);
    cyc(32'h0000_0000, T_IDLE, 1, 0, 0);

    // IDLE / BUSY to an unmapped region: zero-wait OKAY.
    cyc(32'hD000_0000, T_IDLE, 1, 0, 0);
    cyc(32'hD000_0000, T_BUSY, 1, 0, 0);
    dchk("busy_unmapped", 1, 0, 1);
    cyc(32'hD000_0000, T_BUSY, 1, 0, 0);

    // Reset while in DEF_ERR1.
    cyc(32'hE000_0000, T_NSEQ, 1, 0, 0);
    cyc(32'hE000_0000, T_NSEQ, 0, 1, 0);
    cyc(32'h0000_0000, T_IDLE, 1, 0, 0);
    dchk("rst_mid_err", 1, 0, 0);
    chk("rst_mid_err_dsel", 32'(dsel), 32'h0);

    // Randomized traffic, boundary regions included.
    for (int i = 0; i < 600; i++) begin
      int          r;
      logic [31:0] a;
      r = $urandom_range(0, 15);
      a = ($urandom & 32'h0FFF_FFFF) | (32'(r) << 28);
      cyc(a, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0));
    end

`ifdef AHB_DEC_ERRCNT_EN
    // Saturation: far more than 255 unmapped NONSEQ transfers.
    for (int i = 0; i < 620; i++) cyc(32'hE000_0000, T_NSEQ, 1, 0, 0);
    @(negedge hclk); #1;
    chk("cnt_sat", 32'(err_cnt), 32'd255);
    cyc(32'h0000_0000, T_IDLE, 1, 0, 0);
    cyc(32'h0000_0000, T_IDLE, 1, 0, 0);
    cyc(32'hE000_0000, T_NSEQ, 1, 0, 1);
    cyc(32'h0000_0000, T_IDLE, 1, 0, 0);
    @(negedge hclk); #1;
    chk("cnt_clr_wins", 32'(err_cnt), 32'd0);
`endif

    @(negedge hclk); #1;
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
